// File: rtl/linemem_responder_pkg.sv
// linemem_responder_pkg: shared cache geometry constants and responder FSM encoding.
package linemem_responder_pkg;
    localparam int WORD_SIZE        = 32;
    localparam int BYTE_SIZE        = 8;
    localparam int BLOCK_SIZE       = 256;
    localparam int CACHE_OFFSET_LEN = 5;
    localparam int CNT_W            = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;
endpackage

// File: rtl/linemem_array.sv
// linemem_array: zero-initialised line storage, synchronous write, combinational read.
module linemem_array
    import linemem_responder_pkg::*;
#(
    parameter int LINE_BITS   = BLOCK_SIZE,
    parameter int DEPTH_LINES = 64,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     addr,
    input  logic [LINE_BITS-1:0] wdata,
    output logic [LINE_BITS-1:0] rdata
);
    logic [LINE_BITS-1:0] mem [DEPTH_LINES] = '{default: '0};

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

    assign rdata = mem[addr];
endmodule

// File: rtl/linemem_responder.sv
// linemem_responder: handshaked whole-line memory responder with fixed access latency.
// Requests are captured on accept and serviced against linemem_array on the commit edge.
module linemem_responder
    import linemem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = WORD_SIZE,
    parameter int LINE_BITS   = BLOCK_SIZE,
    parameter int OFFSET_LEN  = CACHE_OFFSET_LEN,
    parameter int DEPTH_LINES = 64,
    parameter int LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_BITS-1:0]  req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_write,
    output logic                  resp_err,
    output logic [LINE_BITS-1:0]  resp_rdata
);
    localparam int IDX_W = $clog2(DEPTH_LINES);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  cap_write;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [LINE_BITS-1:0]  cap_wdata;
    logic [LINE_BITS-1:0]  mem_rdata;
    logic [IDX_W-1:0]      idx;
    logic                  accept, commit, err, mem_we;

    assign req_ready  = state == IDLE && !rst;
    assign resp_valid = state == RESP;
    assign accept     = req_valid && req_ready;
    assign commit     = state == WAIT && cnt == '0;
    assign idx        = cap_addr[OFFSET_LEN +: IDX_W];
    assign err        = (cap_addr >> (OFFSET_LEN + IDX_W)) != '0;
    assign mem_we     = commit && cap_write && !err;

    linemem_array #(
        .LINE_BITS  (LINE_BITS),
        .DEPTH_LINES(DEPTH_LINES),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (idx),
        .wdata(cap_wdata),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (accept)                            state_nxt = WAIT;
        else if (commit)                       state_nxt = RESP;
        else if (state == RESP && resp_ready)  state_nxt = IDLE;
    end

    // LATENCY=1 loads cnt=0, so the commit lands on the very next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            resp_write <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                cnt       <= CNT_W'(LATENCY - 1);
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                resp_write <= cap_write;
                resp_err   <= err;
                resp_rdata <= err ? '0 : (cap_write ? cap_wdata : mem_rdata);
            end
        end
    end
endmodule

// File: tb/tb_linemem_responder.sv
// tb_linemem_responder: directed checks of the line responder at LATENCY=4 and LATENCY=1.
module tb_linemem_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [255:0] req_wdata = '0;
    logic         req_ready, resp_valid, resp_write, resp_err;
    logic [255:0] resp_rdata;
    logic         req_valid1 = 1'b0, req_write1 = 1'b0, resp_ready1 = 1'b1;
    logic [31:0]  req_addr1 = '0;
    logic [255:0] req_wdata1 = '0;
    logic         req_ready1, resp_valid1, resp_write1, resp_err1;
    logic [255:0] resp_rdata1;
    int           checks = 0, errors = 0;
    logic [255:0] p1, p2, p3, p4;

    always #5 clk = ~clk;

    linemem_responder dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_err(resp_err), .resp_rdata(resp_rdata)
    );

    linemem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_write(resp_write1),
        .resp_err(resp_err1), .resp_rdata(resp_rdata1)
    );

    task automatic issue(input logic w, input logic [31:0] a, input logic [255:0] d, output int lat);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_write, resp_err} !== 4'b0000 || resp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_hold got rdy=%b v=%b w=%b e=%b rd=%h want all zero", req_ready, resp_valid, resp_write, resp_err, resp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || req_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got rdy=%b rdy1=%b want 1 1", req_ready, req_ready1);
        end
    endtask

    task automatic test_read_zero();
        int lat;
        issue(1'b0, 32'h0000_0040, '0, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL rd0_latency got %0d want 4", lat); end
        checks++;
        if ({resp_valid, resp_write, resp_err} !== 3'b100 || resp_rdata !== '0) begin
            errors++;
            $display("FAIL rd0_resp got v=%b w=%b e=%b rd=%h want v=1 w=0 e=0 rd=0", resp_valid, resp_write, resp_err, resp_rdata);
        end
        handshake();
    endtask

    task automatic test_write_read();
        int lat;
        issue(1'b1, 32'h0000_0060, p1, lat);
        checks++;
        if (lat !== 4 || resp_write !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== p1) begin
            errors++;
            $display("FAIL wr_resp got lat=%0d w=%b e=%b rd=%h want lat=4 w=1 e=0 rd=%h", lat, resp_write, resp_err, resp_rdata, p1);
        end
        handshake();
        issue(1'b0, 32'h0000_007C, '0, lat);
        checks++;
        if (resp_write !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== p1) begin
            errors++;
            $display("FAIL raw_resp got w=%b e=%b rd=%h want w=0 e=0 rd=%h", resp_write, resp_err, resp_rdata, p1);
        end
        handshake();
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [255:0] exp;
        issue(1'b0, 32'h0001_0000, '0, lat);
        checks++;
        if (resp_err !== 1'b1 || resp_rdata !== '0) begin
            errors++;
            $display("FAIL oor_read got e=%b rd=%h want e=1 rd=0", resp_err, resp_rdata);
        end
        handshake();
        issue(1'b1, 32'h0001_0000, {256{1'b1}}, lat);
        checks++;
        if (resp_err !== 1'b1 || resp_write !== 1'b1 || resp_rdata !== '0) begin
            errors++;
            $display("FAIL oor_write got e=%b w=%b rd=%h want e=1 w=1 rd=0", resp_err, resp_write, resp_rdata);
        end
        handshake();
        for (int i = 0; i < 64; i++) begin
            issue(1'b0, 32'(i) << 5, '0, lat);
            exp = (i == 3) ? p1 : '0;
            checks++;
            if (resp_err !== 1'b0 || resp_rdata !== exp) begin
                errors++;
                $display("FAIL oor_line%0d got e=%b rd=%h want e=0 rd=%h", i, resp_err, resp_rdata, exp);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic ok = 1'b1;
        issue(1'b0, 32'h0000_0060, '0, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0080; req_wdata = p2;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== p1 || resp_write !== 1'b0 || req_ready !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_hold got v=%b rdy=%b rd=%h want v=1 rdy=0 rd=%h", resp_valid, req_ready, resp_rdata, p1);
        end
        handshake();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got rdy=%b want 0", req_ready); end
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 4 || resp_write !== 1'b1 || resp_rdata !== p2) begin
            errors++;
            $display("FAIL bp_second got lat=%0d w=%b rd=%h want lat=4 w=1 rd=%h", lat, resp_write, resp_rdata, p2);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0020; req_wdata = p3;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_write, resp_err} !== 4'b0000 || resp_rdata !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got rdy=%b v=%b w=%b e=%b rd=%h want all zero", req_ready, resp_valid, resp_write, resp_err, resp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready);
        end
        issue(1'b0, 32'h0000_0020, '0, lat);
        checks++;
        if (resp_rdata !== '0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_old got rd=%h e=%b want rd=0 e=0", resp_rdata, resp_err);
        end
        handshake();
    endtask

    task automatic test_back_to_back_lat1();
        req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 32'h0000_0040; req_wdata1 = p4;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            checks++;
            if (req_ready1 !== (k % 3 == 2) || resp_valid1 !== (k % 3 == 1)) begin
                errors++;
                $display("FAIL lat1_cycle%0d got rdy=%b v=%b want rdy=%b v=%b", k, req_ready1, resp_valid1, k % 3 == 2, k % 3 == 1);
            end
            if (k % 3 == 1) begin
                checks++;
                if (resp_rdata1 !== p4 || resp_write1 !== 1'b1) begin
                    errors++;
                    $display("FAIL lat1_data%0d got w=%b rd=%h want w=1 rd=%h", k, resp_write1, resp_rdata1, p4);
                end
            end
        end
        req_valid1 = 1'b0;
    endtask

    initial begin
        p1 = {8{32'hDEADBEEF}};
        p2 = {8{32'h1234_5678}};
        p3 = {8{32'hCAFE_F00D}};
        p4 = {8{32'hA5A5_0F0F}};
        test_reset();
        test_read_zero();
        test_write_read();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_back_to_back_lat1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
